divider_arbiter: RTL and testbench
==================================

# divider_arbiter

Shares one iterative `divider` instance between two requesters inside the FPU divide path. A round-robin arbiter grants one request at a time and sequences the divider: load pulse, fixed iteration window, then result capture. It returns quotient/remainder with the requester ID over a valid/ready response channel. Sits between the mantissa-divide issue logic and the `divider` datapath.

## Interface
- `WIDTH`, 30, operand/result width; passed to the divider instance.
- `CYCLES`, 30, iteration count; driven on `div_init` and used as the run-window length; must be ≥1 and < 2^WIDTH.
- `clk` in 1 — single clock; all logic on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `req0_valid` in 1 — requester 0 has an operation.
- `req0_ready` out 1 — requester 0 accepted this cycle.
- `req0_num`, `req0_den` in WIDTH — requester 0 numerator and denominator.
- `req1_valid`, `req1_ready`, `req1_num`, `req1_den` — same for requester 1.
- `rsp_valid` out 1 — result available.
- `rsp_ready` in 1 — consumer takes the result.
- `rsp_id` out 1 — requester that owns the result.
- `rsp_q`, `rsp_r` out WIDTH — quotient, remainder.
- `rsp_dz` out 1 — divide-by-zero flag.
- `div_rst` out 1 — load/reset pulse to the divider `rst`.
- `div_en` out 1 — divider `enable`.
- `div_init` out WIDTH — divider `initCounter`, constant `CYCLES`.
- `div_n`, `div_d` out WIDTH — operands to the divider `N`, `D`.
- `div_q`, `div_r` in WIDTH — divider `QO`, `RO`.

## Operation
- FSM states: IDLE, LOAD, RUN, RESP.
- IDLE: if either `reqX_valid`, grant one. `reqX_ready` is combinational and asserted only in IDLE for the granted requester. On grant, capture num/den into `div_n`/`div_d`, record ID, go to LOAD.
- Arbitration: if both are valid, grant the requester not granted last. `last` pointer resets to 1, so req0 wins the first tie. If only one is valid, grant it. The pointer updates on every grant.
- LOAD: `div_rst`=1 for exactly one cycle. Load the iteration counter with `CYCLES`. Go to RUN.
- RUN: `div_en`=1. Decrement the counter each cycle. In the cycle the counter reads 1, register `div_q`/`div_r` into `rsp_q`/`rsp_r` and go to RESP.
- RESP: `rsp_valid`=1. Hold all `rsp_*` stable until `rsp_ready`. On handshake, return to IDLE. No new grant is made in the handshake cycle.
- `div_n`/`div_d` stay stable from LOAD through the end of RUN.
- `div_rst` = `rst` OR (state==LOAD), so a system reset also clears the divider.
- Reset values (also on reset mid-operation): state IDLE; `rsp_valid`, `rsp_id`, `rsp_q`, `rsp_r`, `rsp_dz`, `div_en`, `div_n`, `div_d` all 0; `reqX_ready` 0; `div_rst` 1 while `rst` is high. An in-flight operation is discarded with no response.

## Timing
- Request accepted at edge T.
- `div_rst` is high during cycle T+1.
- `div_en` is high during cycles T+2 … T+1+`CYCLES`.
- `rsp_valid` rises at T+2+`CYCLES`. Minimum request-to-response latency is `CYCLES`+2 cycles.
- Throughput: one operation per `CYCLES`+3 cycles when `rsp_ready` is tied high.
- A `reqX_valid` that drops before grant is simply not serviced. Request-side valids are not required to be sticky.
- `rsp_ready` asserted before `rsp_valid` has no effect.

## Configuration
- `DIV_ZERO_CHECK_EN` defined:
  - A granted request with den==0 skips LOAD and RUN and goes to RESP on the next edge.
  - Response: `rsp_q` = all ones, `rsp_r` = num, `rsp_dz` = 1.
  - `div_rst`, `div_en`, `div_n` and `div_d` are not changed for that request.
  - The arbitration pointer updates as normal.
- `DIV_ZERO_CHECK_EN` undefined:
  - A zero denominator goes through the divider like any other request, and the result is whatever the divider produces.
  - `rsp_dz` is tied to 0.

## Test plan
- **Single request.** req0 with num=0x0380E73 (WIDTH=30, CYCLES=30), den=0x0140380, `rsp_ready`=1 → `req0_ready` pulses once; one `div_rst` pulse; exactly 30 `div_en` cycles; `rsp_valid` at accept+32; `rsp_id`=0; `rsp_q`/`rsp_r` equal the divider outputs (a reference model of num/den).
- **Tie and round-robin.** req0 and req1 held valid continuously → grant order after reset is 0,1,0,1. Each response carries the matching `rsp_id` and operands.
- **Back-pressure.** `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_*` stable; both `reqX_ready`=0; no `div_rst`. Release `rsp_ready` → return to IDLE the next cycle.
- **Reset mid-RUN.** Assert `rst` at accept+10 → all outputs at reset values immediately; `div_rst` high; no response. After release, a new req1 completes normally.
- **Divide by zero.**
  - With `DIV_ZERO_CHECK_EN`: den=0, num=5 → `rsp_valid` at accept+1, q=0x3FFFFFFF, r=5, dz=1, no `div_rst` pulse.
  - Without the macro: full `CYCLES`+2 latency and dz=0.

Source files
------------

// File: rtl/divider_arbiter.sv
// Round-robin front end sharing one iterative divider between two requesters.
// Optional DIV_ZERO_CHECK_EN answers zero-denominator requests without the divider.
module divider_arbiter #(
    parameter int WIDTH  = 30,
    parameter int CYCLES = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_num,
    input  logic [WIDTH-1:0] req0_den,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_num,
    input  logic [WIDTH-1:0] req1_den,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_q,
    output logic [WIDTH-1:0] rsp_r,
    output logic             rsp_dz,
    output logic             div_rst,
    output logic             div_en,
    output logic [WIDTH-1:0] div_init,
    output logic [WIDTH-1:0] div_n,
    output logic [WIDTH-1:0] div_d,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    localparam logic [WIDTH-1:0] INIT = WIDTH'(CYCLES);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state;
    state_t           state_nx;
    logic             last;
    logic [WIDTH-1:0] cnt;
    logic             g0;
    logic             g1;
    logic             grant;
    logic             gid;
    logic             dz_hit;
    logic [WIDTH-1:0] sel_num;
    logic [WIDTH-1:0] sel_den;

    // On a tie the requester not served last wins; last=1 favours req0.
    assign g0      = req0_valid & (~req1_valid | last);
    assign g1      = req1_valid & (~req0_valid | ~last);
    assign grant   = (state == IDLE) & ~rst & (g0 | g1);
    assign gid     = ~g0;
    assign sel_num = gid ? req1_num : req0_num;
    assign sel_den = gid ? req1_den : req0_den;
    assign div_init = INIT;

`ifdef DIV_ZERO_CHECK_EN
    assign dz_hit = (sel_den == '0);
`else
    assign dz_hit = 1'b0;
    assign rsp_dz = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        div_en     = 1'b0;
        rsp_valid  = 1'b0;
        div_rst    = rst;
        unique case (state)
            IDLE: begin
                req0_ready = grant & g0;
                req1_ready = grant & g1;
                if (grant) begin
                    state_nx = dz_hit ? RESP : LOAD;
                end
            end
            LOAD: begin
                div_rst  = 1'b1;
                state_nx = RUN;
            end
            RUN: begin
                div_en = 1'b1;
                if (cnt == ONE) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last   <= 1'b1;
            rsp_id <= 1'b0;
            rsp_q  <= '0;
            rsp_r  <= '0;
            div_n  <= '0;
            div_d  <= '0;
            cnt    <= '0;
`ifdef DIV_ZERO_CHECK_EN
            rsp_dz <= 1'b0;
`endif
        end else begin
            if (grant) begin
                last   <= gid;
                rsp_id <= gid;
`ifdef DIV_ZERO_CHECK_EN
                rsp_dz <= dz_hit;
                if (dz_hit) begin
                    rsp_q <= '1;
                    rsp_r <= sel_num;
                end else begin
                    div_n <= sel_num;
                    div_d <= sel_den;
                end
`else
                div_n <= sel_num;
                div_d <= sel_den;
`endif
            end
            if (state == LOAD) begin
                cnt <= INIT;
            end
            if (state == RUN) begin
                cnt <= cnt - ONE;
                // Sample on the last enabled cycle, while the divider holds its result.
                if (cnt == ONE) begin
                    rsp_q <= div_q;
                    rsp_r <= div_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Scoreboard bench for divider_arbiter with a behavioural divider model.
// Expectations follow DIV_ZERO_CHECK_EN when it is defined.
module tb_divider_arbiter;

    localparam int W = 30;
    localparam int C = 30;

    typedef struct {
        logic         id;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           en;
        int           rs;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 1'b0;
    logic         req0_ready;
    logic [W-1:0] req0_num = '0;
    logic [W-1:0] req0_den = '0;
    logic         req1_valid = 1'b0;
    logic         req1_ready;
    logic [W-1:0] req1_num = '0;
    logic [W-1:0] req1_den = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic         rsp_id;
    logic [W-1:0] rsp_q;
    logic [W-1:0] rsp_r;
    logic         rsp_dz;
    logic         div_rst;
    logic         div_en;
    logic [W-1:0] div_init;
    logic [W-1:0] div_n;
    logic [W-1:0] div_d;
    logic [W-1:0] div_q;
    logic [W-1:0] div_r;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int en_cnt = 0;
    int rs_cnt = 0;
    exp_t sb[$];
    logic glog[$];

    logic         p_valid = 1'b0;
    logic         p_ready = 1'b0;
    logic         p_id;
    logic [W-1:0] p_q;
    logic [W-1:0] p_r;
    logic         p_dz;

    divider_arbiter #(.WIDTH(W), .CYCLES(C)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_num(req0_num), .req0_den(req0_den),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_num(req1_num), .req1_den(req1_den),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz),
        .div_rst(div_rst), .div_en(div_en), .div_init(div_init),
        .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r)
    );

    always #5 clk = ~clk;

    // Behavioural divider: settled quotient/remainder of the held operands.
    assign div_q = (div_d == '0) ? '1 : div_n / div_d;
    assign div_r = (div_d == '0) ? div_n : div_n % div_d;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic id, input logic [W-1:0] n,
                                input logic [W-1:0] d);
        exp_t e;
        e.id  = id;
        e.num = n;
        e.den = d;
        e.q   = (d == '0) ? '1 : n / d;
        e.r   = (d == '0) ? n : n % d;
`ifdef DIV_ZERO_CHECK_EN
        e.dz  = (d == '0);
`else
        e.dz  = 1'b0;
`endif
        e.lat = e.dz ? 1 : C + 2;
        e.en  = e.dz ? 0 : C;
        e.rs  = e.dz ? 0 : 1;
        return e;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            en_cnt  = 0;
            rs_cnt  = 0;
            p_valid = 1'b0;
            p_ready = 1'b0;
        end else begin
            if (div_en) en_cnt++;
            if (div_rst) rs_cnt++;
            if (req0_ready && req1_ready) chk("dual_ready", 1, 0);
            if (req0_ready && req0_valid) begin
                sb.push_back(mk(1'b0, req0_num, req0_den));
                glog.push_back(1'b0);
                acc_cyc = cyc;
                en_cnt  = 0;
                rs_cnt  = 0;
            end else if (req1_ready && req1_valid) begin
                sb.push_back(mk(1'b1, req1_num, req1_den));
                glog.push_back(1'b1);
                acc_cyc = cyc;
                en_cnt  = 0;
                rs_cnt  = 0;
            end
            if (div_en && sb.size() > 0) begin
                chk("run_ops", {div_n, div_d}, {sb[0].num, sb[0].den});
            end
            if (rsp_valid && !p_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    chk("latency", cyc - acc_cyc, sb[0].lat);
                    chk("en_cycles", en_cnt, sb[0].en);
                    chk("rst_pulses", rs_cnt, sb[0].rs);
                end
            end
            if (rsp_valid && p_valid && !p_ready) begin
                chk("stall_hold", {rsp_id, rsp_dz, rsp_q, rsp_r},
                    {p_id, p_dz, p_q, p_r});
            end
            if (rsp_valid) begin
                chk("resp_quiet", {req0_ready, req1_ready, div_rst}, 0);
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", 1, 0);
                end else begin
                    chk("rsp_id", rsp_id, sb[0].id);
                    chk("rsp_q", rsp_q, sb[0].q);
                    chk("rsp_r", rsp_r, sb[0].r);
                    chk("rsp_dz", rsp_dz, sb[0].dz);
                    void'(sb.pop_front());
                end
            end
            p_valid = rsp_valid;
            p_ready = rsp_ready;
            p_id    = rsp_id;
            p_q     = rsp_q;
            p_r     = rsp_r;
            p_dz    = rsp_dz;
        end
    end

    task automatic issue(input logic id, input logic [W-1:0] n,
                         input logic [W-1:0] d);
        bit ok = 0;
        if (id) begin
            req1_num = n; req1_den = d; req1_valid = 1'b1;
        end else begin
            req0_num = n; req0_den = d; req0_valid = 1'b1;
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (id ? req1_ready : req0_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("grant_timeout", 0, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !rsp_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk(tag, 0, 1);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctl", {rsp_valid, rsp_id, rsp_dz, div_en,
                        req0_ready, req1_ready, div_rst}, 7'b0000001);
        chk("rst_data", {rsp_q, rsp_r, div_n, div_d}, 0);
        chk("div_init", div_init, C);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        rst = 1'b0;

        rsp_ready = 1'b1;
        issue(1'b0, 30'h0380E73, 30'h0140380);
        drain("single_drain");

        do_reset();
        glog.delete();
        req0_num = 30'h1234567; req0_den = 30'h0000321;
        req1_num = 30'h3ABCDEF; req1_den = 30'h0001234;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (glog.size() >= 4) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("rr_count", glog.size(), 4);
        for (int i = 0; i < 4 && i < glog.size(); i++) begin
            chk("rr_order", glog[i], i % 2);
        end
        drain("rr_drain");

        rsp_ready = 1'b0;
        issue(1'b1, 30'h2000000, 30'h0000007);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) break;
        end
        req0_num = 30'h0000FFF; req0_den = 30'h0000010;
        req0_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_after_hs", req0_ready, 1);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        drain("bp_drain");

        issue(1'b0, 30'h3FFFFFF, 30'h0000003);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_ctl", {rsp_valid, div_en, div_rst, req0_ready,
                           req1_ready}, 5'b00100);
        chk("midrst_data", {rsp_q, rsp_r, div_n, div_d, rsp_id}, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1'b1, 30'h0ABCDEF, 30'h0000100);
        drain("midrst_drain");

        issue(1'b0, 30'd5, 30'd0);
        drain("dz_drain");

        for (int i = 0; i < 4; i++) begin
            issue(i[0], W'($urandom), W'($urandom_range(1, 5000)));
            drain("rand_drain");
        end

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
